m_arith_counter: RTL and testbench
==================================

// Module: m_arith_counter
// PURPOSE
//  - Loadable up/down counter built on an adder core, with a magnitude comparator of the count
//    against a compare input.
//  - Generic datapath primitive for the vector rasterizer: major/minor step counters and the
//    loop-termination compare (majCnt vs denominator).
//  - Combines the m_counter, m_adder and m_comparator behaviours in one block.
// PARAMETERS
//  - W          14  datapath width of D, Q, cmp, delta
//  - CMP_SIGNED 0   0: comparator treats Q/cmp as unsigned; 1: as two's complement
// PORTS
//  - clk    in  1  single clock, all state updates on posedge
//  - clr    in  1  reset, synchronous, active-high; clears Q
//  - load   in  1  synchronous load of D into Q
//  - en     in  1  count enable
//  - up     in  1  1: Q += step; 0: Q -= step
//  - D      in  W  load value
//  - delta  in  W  step size; port exists only with COUNTER_VAR_DELTA_EN
//  - cmp    in  W  compare operand
//  - Q      out W  registered count
//  - AgtB   out 1  comb: Q > cmp
//  - AeqB   out 1  comb: Q == cmp
//  - AltB   out 1  comb: Q < cmp
//  - wrap   out 1  comb: the next enabled step crosses modulo 2^W (carry when up, borrow when down)
// BEHAVIOUR
//  - Reset: one clock, synchronous, active-high. Clock port is clk; reset port is clr.
//  - After clr: Q = 0; flags reflect 0 vs cmp; wrap reflects 0 +/- step.
//  - Priority per posedge: clr > load > en > hold.
//    - load and en both high: load wins, no step applied.
//  - Latency:
//    - Count step: Q updates 1 cycle after en is sampled.
//    - Load: Q = D on the next edge.
//  - Step: 1 without the macro; delta with it. delta = 0 holds Q even when en = 1.
//  - Arithmetic uses one W-bit adder instance with carry-in and carry-out:
//    - up = 1: sum = Q + step, cin = 0.
//    - up = 0: sum = Q + ~step, cin = 1 (two's-complement subtract).
//  - Wrap-around is modulo 2^W; no saturation.
//    - Up: wrap = cout; 2^W-1 + 1 -> 0.
//    - Down: wrap = ~cout; 0 - 1 -> 2^W-1.
//    - wrap is valid whether or not en is high.
//  - Comparator:
//    - Exactly one of AgtB/AeqB/AltB is high at any time.
//    - Purely combinational from current Q and cmp.
//    - Signedness set by CMP_SIGNED.
//  - Mid-operation clr discards any pending load or step. No X on outputs after the first reset edge.
//  - Inputs are sampled only at posedge. No internal state besides Q.
// CONFIGURATION
//  - Macro COUNTER_VAR_DELTA_EN.
//  - Defined: delta input port present; step = delta (variable stride, e.g. 2 for the double-pixel
//    rasterizer).
//  - Undefined: no delta port; step fixed at 1 (plain m_counter behaviour).
// STRUCTURE
//  - Shared package arith_pkg:
//    - localparam DEFAULT_W = 14.
//    - typedef enum logic {DIR_DOWN = 0, DIR_UP = 1} dir_t, used for the up input.
//  - One sub-module m_adder #(W): (sum, cout, A, B, cin). Purely combinational; sum = A + B + cin;
//    cout is the W-th carry bit.
//  - Comparator and next-state mux are inline always_comb.
// TESTING
//  - clr=1 one cycle with load=1, D=14'd99 -> Q=0 next edge (clr beats load).
//  - load=1, D=14'd5, en=1 -> Q=5 (no step). Then en=1, up=1 for 3 cycles -> Q=8.
//  - Q=0, up=0, en=1 -> wrap=1 before the edge; Q=14'h3FFF after. Q=14'h3FFF, up=1 -> wrap=1,
//    Q=0 next.
//  - cmp=14'd8 with Q stepping 6,7,8,9 -> AltB,AltB,AeqB,AgtB. CMP_SIGNED=1, Q=14'h3FFF,
//    cmp=1 -> AltB=1.
//  - COUNTER_VAR_DELTA_EN, delta=2, load D=0, 4 enabled cycles up -> Q=8; delta=0 -> Q holds.
//  - en=0 with up toggling for 5 cycles -> Q unchanged; flags stable.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types and defaults for the arithmetic counter datapath.
package arith_pkg;
    localparam int DEFAULT_W = 14;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;
endpackage

// File: rtl/m_adder.sv
// W-bit combinational adder with carry-in and carry-out.
// Latency: 0 cycles (pure combinational). Backpressure: none.
module m_adder #(
    parameter int W = 14
) (
    output logic [W-1:0] sum,
    output logic         cout,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         cin
);
    assign {cout, sum} = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, cin};
endmodule

// File: rtl/m_arith_counter.sv
// Loadable up/down counter on one adder, plus magnitude compare of Q vs cmp; COUNTER_VAR_DELTA_EN adds a delta stride port.
// Latency: Q updates on the edge after load/en is sampled; flags and wrap are combinational. Backpressure: none.
module m_arith_counter
    import arith_pkg::*;
#(
    parameter int W          = DEFAULT_W,
    parameter bit CMP_SIGNED = 1'b0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  dir_t         up,
    input  logic [W-1:0] D,
`ifdef COUNTER_VAR_DELTA_EN
    input  logic [W-1:0] delta,
`endif
    input  logic [W-1:0] cmp,
    output logic [W-1:0] Q,
    output logic         AgtB,
    output logic         AeqB,
    output logic         AltB,
    output logic         wrap
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic [W-1:0] step;
    logic [W-1:0] b_op;
    logic [W-1:0] sum;
    logic         cin;
    logic         cout;
    logic         gt;
    logic         eq;

    // Down-counting is Q + ~step + 1, so one adder serves both directions.
    always_comb begin
`ifdef COUNTER_VAR_DELTA_EN
        step = delta;
`else
        step = {{(W-1){1'b0}}, 1'b1};
`endif
        b_op = (up == DIR_UP) ? step : ~step;
        cin  = (up == DIR_DOWN);
    end

    m_adder #(.W(W)) u_adder (
        .sum  (sum),
        .cout (cout),
        .A    (q_q),
        .B    (b_op),
        .cin  (cin)
    );

    // A borrow on subtract shows up as a missing carry-out.
    assign wrap = (up == DIR_UP) ? cout : ~cout;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = D;
        end else if (en) begin
            q_d = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    always_comb begin
        eq = (q_q == cmp);
        if (CMP_SIGNED) begin
            gt = ($signed(q_q) > $signed(cmp));
        end else begin
            gt = (q_q > cmp);
        end
    end

    assign Q    = q_q;
    assign AeqB = eq;
    assign AgtB = gt;
    assign AltB = ~gt & ~eq;
endmodule

// File: tb/tb_m_arith_counter.sv
// Bench for m_arith_counter: directed vectors, a per-cycle arithmetic model, and pinned literal checks.
module tb_m_arith_counter;
    import arith_pkg::*;

    localparam int W = 14;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         clr;
    logic         load;
    logic         en;
    dir_t         up;
    logic [W-1:0] D;
    logic [W-1:0] delta;
    logic [W-1:0] cmp;

    logic [W-1:0] q_u, q_s;
    logic         gt_u, eq_u, lt_u, wr_u;
    logic         gt_s, eq_s, lt_s, wr_s;

    int n_checks = 0;
    int n_pass   = 0;

    int mq     = 0;
    bit mvalid = 1'b0;

    always #5 clk = ~clk;

    m_arith_counter #(.W(W), .CMP_SIGNED(1'b0)) u_dut (
        .clk   (clk),
        .clr   (clr),
        .load  (load),
        .en    (en),
        .up    (up),
        .D     (D),
`ifdef COUNTER_VAR_DELTA_EN
        .delta (delta),
`endif
        .cmp   (cmp),
        .Q     (q_u),
        .AgtB  (gt_u),
        .AeqB  (eq_u),
        .AltB  (lt_u),
        .wrap  (wr_u)
    );

    m_arith_counter #(.W(W), .CMP_SIGNED(1'b1)) u_sgn (
        .clk   (clk),
        .clr   (clr),
        .load  (load),
        .en    (en),
        .up    (up),
        .D     (D),
`ifdef COUNTER_VAR_DELTA_EN
        .delta (delta),
`endif
        .cmp   (cmp),
        .Q     (q_s),
        .AgtB  (gt_s),
        .AeqB  (eq_s),
        .AltB  (lt_s),
        .wrap  (wr_s)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cur_step();
`ifdef COUNTER_VAR_DELTA_EN
        return int'(delta);
`else
        return 1;
`endif
    endfunction

    function automatic int sx(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    // Model: integer arithmetic modulo 2^W with the clr > load > en > hold rule.
    always @(posedge clk) begin
        if (clr) begin
            mq     = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            if (load) begin
                mq = int'(D);
            end else if (en) begin
                if (up == DIR_UP) mq = (mq + cur_step()) % M;
                else              mq = (mq - cur_step() + M) % M;
            end
        end
    end

    always @(negedge clk) begin
        int st, c, exp_wrap;
        if (mvalid) begin
            st       = cur_step();
            c        = int'(cmp);
            exp_wrap = (up == DIR_UP) ? int'(mq + st >= M) : int'(st > mq);
            check("q_u",  int'(q_u),  mq);
            check("q_s",  int'(q_s),  mq);
            check("gt_u", int'(gt_u), int'(mq > c));
            check("eq_u", int'(eq_u), int'(mq == c));
            check("lt_u", int'(lt_u), int'(mq < c));
            check("wrap", int'(wr_u), exp_wrap);
            check("gt_s", int'(gt_s), int'(sx(mq) > sx(c)));
            check("eq_s", int'(eq_s), int'(mq == c));
            check("lt_s", int'(lt_s), int'(sx(mq) < sx(c)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_q[4];
        int exp_f[4];
        exp_q = '{6, 7, 8, 9};
        exp_f = '{0, 0, 1, 2};  // 0: lt, 1: eq, 2: gt

        clr = 1'b1; load = 1'b1; D = 14'd99; en = 1'b0; up = DIR_UP;
        cmp = 14'd8; delta = 14'd1;
        tick();
        check("clr_beats_load", int'(q_u), 0);

        clr = 1'b0; load = 1'b1; D = 14'd5; en = 1'b1;
        tick();
        check("load_over_en", int'(q_u), 5);

        load = 1'b0;
        repeat (3) tick();
        check("count_up3", int'(q_u), 8);

        load = 1'b1; D = 14'd6; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            load = 1'b0; en = 1'b1;
            check("cmp_q",    int'(q_u),  exp_q[i]);
            check("cmp_lt",   int'(lt_u), int'(exp_f[i] == 0));
            check("cmp_eq",   int'(eq_u), int'(exp_f[i] == 1));
            check("cmp_gt",   int'(gt_u), int'(exp_f[i] == 2));
        end

        clr = 1'b1; load = 1'b1; D = 14'd77; en = 1'b1;
        tick();
        check("clr_mid", int'(q_u), 0);

        clr = 1'b0; load = 1'b0; en = 1'b0; up = DIR_DOWN;
        #1;
        check("wrap_down_pre", int'(wr_u), 1);
        en = 1'b1;
        tick();
        check("wrap_down_q", int'(q_u), 16'h3FFF);

        en = 1'b0; up = DIR_UP; cmp = 14'd1;
        #1;
        check("wrap_up_pre", int'(wr_u), 1);
        check("sgn_lt",      int'(lt_s), 1);
        check("uns_gt",      int'(gt_u), 1);
        en = 1'b1;
        tick();
        check("wrap_up_q", int'(q_u), 0);

        en = 1'b0; cmp = 14'd8;
        for (int i = 0; i < 5; i++) begin
            up = (up == DIR_UP) ? DIR_DOWN : DIR_UP;
            tick();
            check("hold_q",  int'(q_u),  0);
            check("hold_lt", int'(lt_u), 1);
        end

`ifdef COUNTER_VAR_DELTA_EN
        delta = 14'd2; load = 1'b1; D = 14'd0; en = 1'b0; up = DIR_UP;
        tick();
        load = 1'b0; en = 1'b1;
        repeat (4) tick();
        check("delta2_q", int'(q_u), 8);
        delta = 14'd0;
        repeat (2) tick();
        check("delta0_hold", int'(q_u), 8);
        delta = 14'd1;
`endif

        en = 1'b0;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
